// File: rtl/ff_excite_driver.sv
// Flip-flop excitation driver: derives JK/T drive for a target word, clocks an internal
// bank with the characteristic equation and checks it. Optional feature: FF_FAULT_INJECT_EN.
module ff_excite_driver #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_Q   = '0,
  parameter int unsigned      ERR_CNT_W = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     inj_mask,
  output logic [WIDTH-1:0]     J,
  output logic [WIDTH-1:0]     K,
  output logic [WIDTH-1:0]     T,
  output logic [WIDTH-1:0]     Q,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXCITE = 2'd1,
    APPLY  = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tgt;
  logic             mode_r;
  logic             accept;
  logic [WIDTH-1:0] inj;
  logic [WIDTH-1:0] j_calc, k_calc, t_calc;

  assign in_ready = (state == IDLE);

`ifdef FF_FAULT_INJECT_EN
  assign inj = inj_mask;
`else
  logic unused_inj;
  assign inj        = '0;
  assign unused_inj = ^inj_mask;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = EXCITE;
        end
      end
      EXCITE:  state_nxt = APPLY;
      APPLY:   state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Excitation table with don't-cares resolved to 0: only bits that must move get a drive.
  always_comb begin
    j_calc = (tgt & ~Q) ^ inj;
    k_calc = (~tgt & Q) ^ inj;
    t_calc = (tgt ^ Q) ^ inj;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Q      <= RESET_Q;
      J      <= '0;
      K      <= '0;
      T      <= '0;
      done   <= 1'b0;
      tgt    <= '0;
      mode_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tgt    <= in_data;
            mode_r <= mode;
          end
        end
        EXCITE: begin
          if (mode_r) begin
            T <= t_calc;
            J <= '0;
            K <= '0;
          end else begin
            J <= j_calc;
            K <= k_calc;
            T <= '0;
          end
        end
        APPLY: begin
          if (mode_r) Q <= Q ^ T;
          else        Q <= (J & ~Q) | (~K & Q);
          J <= '0;
          K <= '0;
          T <= '0;
        end
        CHECK:   done <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef FF_FAULT_INJECT_EN
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= 1'b0;
      if (state == CHECK) begin
        err <= (Q != tgt);
        if ((Q != tgt) && (err_cnt != '1)) err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule
